// File: rtl/noc_output_vc_arbiter.sv
// Output-port scheduler for a NoC router: round-robin over input ports with
// per-VC wormhole locking and downstream credit tracking. Grants are same-cycle.
module noc_output_vc_arbiter #(
    parameter int NUM_IN       = 5,
    parameter int NUM_VC       = 2,
    parameter int VC_W         = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    parameter int CREDIT_DEPTH = 4,
    localparam int CNT_W       = $clog2(CREDIT_DEPTH + 1),
    localparam int SEL_W       = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                      noc_clk,
    input  logic                      noc_rst,
    input  logic [NUM_IN-1:0]         req,
    input  logic [NUM_IN*VC_W-1:0]    req_vc,
    input  logic [NUM_IN-1:0]         req_head,
    input  logic [NUM_IN-1:0]         req_tail,
    input  logic [NUM_VC-1:0]         credit_return,
    output logic [NUM_IN-1:0]         grant,
    output logic                      out_valid,
    output logic [VC_W-1:0]           out_vc,
    output logic [SEL_W-1:0]          out_sel,
    output logic [NUM_VC*CNT_W-1:0]   credit_cnt,
    output logic                      err
);

    logic [CNT_W-1:0]  credit_r [NUM_VC];
    logic [NUM_VC-1:0] busy_r;
    logic [SEL_W-1:0]  owner_r [NUM_VC];
    logic [SEL_W-1:0]  rr_ptr_r;
    logic              err_r;

    logic [VC_W-1:0]   vc_s [NUM_IN];
    logic [NUM_IN-1:0] elig_s;
    logic [NUM_IN-1:0] head_err_s;
    logic              found_s;
    logic [SEL_W-1:0]  win_s;
    logic [VC_W-1:0]   win_vc_s;
    logic              win_tail_s;
    logic [NUM_VC-1:0] vc_grant_s;
    logic              overflow_s;

    // Split the packed VC request vector into per-input indices.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            vc_s[i] = req_vc[i*VC_W +: VC_W];
        end
    end

    // Eligibility: a head may claim an idle VC, only the owner's body/tail may use a busy one.
    always_comb begin
        elig_s     = '0;
        head_err_s = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (req[i] && busy_r[vc_s[i]] && (owner_r[vc_s[i]] == SEL_W'(i))) begin
                head_err_s[i] = req_head[i];
                elig_s[i]     = !req_head[i] && (credit_r[vc_s[i]] != '0);
            end else if (req[i] && !busy_r[vc_s[i]]) begin
                elig_s[i]     = req_head[i] && (credit_r[vc_s[i]] != '0);
            end else begin
                elig_s[i]     = 1'b0;
            end
        end
    end

    // Round-robin scan starting at rr_ptr for the first eligible input.
    always_comb begin
        int idx;
        idx     = 0;
        found_s = 1'b0;
        win_s   = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = int'(rr_ptr_r) + k;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end else begin
                idx = idx;
            end
            if (!found_s && elig_s[idx]) begin
                found_s = 1'b1;
                win_s   = SEL_W'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Winner attributes, per-VC grant decode and credit overflow detection.
    always_comb begin
        if (found_s) begin
            win_vc_s   = vc_s[win_s];
            win_tail_s = req_tail[win_s];
        end else begin
            win_vc_s   = '0;
            win_tail_s = 1'b0;
        end
        overflow_s = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            vc_grant_s[v] = found_s && (win_vc_s == VC_W'(v));
            if (credit_return[v] && !vc_grant_s[v] && (credit_r[v] == CNT_W'(CREDIT_DEPTH))) begin
                overflow_s = 1'b1;
            end else begin
                overflow_s = overflow_s;
            end
        end
    end

    // Output drive: combinational so the crossbar sees the grant in the request cycle.
    always_comb begin
        grant = '0;
        if (found_s) begin
            grant[win_s] = 1'b1;
        end else begin
            grant = '0;
        end
        out_valid = found_s;
        out_vc    = win_vc_s;
        out_sel   = win_s;
        for (int v = 0; v < NUM_VC; v++) begin
            credit_cnt[v*CNT_W +: CNT_W] = credit_r[v];
        end
        err = err_r;
    end

    // State update: round-robin pointer, per-VC locks and credits, sticky error.
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                credit_r[v] <= CNT_W'(CREDIT_DEPTH);
                owner_r[v]  <= '0;
            end
            busy_r   <= '0;
            rr_ptr_r <= '0;
            err_r    <= 1'b0;
        end else begin
            if (found_s) begin
                rr_ptr_r <= (win_s == SEL_W'(NUM_IN - 1)) ? '0 : win_s + SEL_W'(1);
            end
            for (int v = 0; v < NUM_VC; v++) begin
                if (vc_grant_s[v] && !credit_return[v]) begin
                    credit_r[v] <= credit_r[v] - CNT_W'(1);
                end else if (!vc_grant_s[v] && credit_return[v] &&
                             (credit_r[v] != CNT_W'(CREDIT_DEPTH))) begin
                    credit_r[v] <= credit_r[v] + CNT_W'(1);
                end
                // Eligibility guarantees a head on an idle VC and a non-head on a busy one.
                if (vc_grant_s[v]) begin
                    if (!busy_r[v]) begin
                        if (!win_tail_s) begin
                            busy_r[v]  <= 1'b1;
                            owner_r[v] <= win_s;
                        end
                    end else if (win_tail_s) begin
                        busy_r[v] <= 1'b0;
                    end
                end
            end
            err_r <= err_r | (|head_err_s) | overflow_s;
        end
    end

endmodule

// File: tb/tb_noc_output_vc_arbiter.sv
// Self-checking bench for noc_output_vc_arbiter: directed scenarios plus a
// randomized run, all compared against a behavioural scheduler model.
module tb_noc_output_vc_arbiter;

    localparam int NUM_IN = 5;
    localparam int NUM_VC = 2;
    localparam int DEPTH  = 4;

    logic       noc_clk = 1'b0;
    logic       noc_rst;
    logic [4:0] req, req_vc, req_head, req_tail;
    logic [1:0] credit_return;
    logic [4:0] grant;
    logic       out_valid;
    logic [0:0] out_vc;
    logic [2:0] out_sel;
    logic [5:0] credit_cnt;
    logic       err;

    int n_vec = 0;
    int n_bad = 0;

    int m_credit [NUM_VC];
    bit m_busy   [NUM_VC];
    int m_owner  [NUM_VC];
    int m_rr;
    bit m_err;

    noc_output_vc_arbiter dut (
        .noc_clk(noc_clk), .noc_rst(noc_rst), .req(req), .req_vc(req_vc),
        .req_head(req_head), .req_tail(req_tail), .credit_return(credit_return),
        .grant(grant), .out_valid(out_valid), .out_vc(out_vc), .out_sel(out_sel),
        .credit_cnt(credit_cnt), .err(err)
    );

    always #5 noc_clk = ~noc_clk;

    function automatic int model_winner();
        for (int k = 0; k < NUM_IN; k++) begin
            int i = (m_rr + k) % NUM_IN;
            int v = int'(req_vc[i]);
            if (req[i] && m_credit[v] > 0) begin
                if (!m_busy[v] && req_head[i]) return i;
                if (m_busy[v] && m_owner[v] == i && !req_head[i]) return i;
            end
        end
        return -1;
    endfunction

    function automatic logic [4:0] exp_grant();
        logic [4:0] g;
        int w;
        g = 5'b00000;
        w = model_winner();
        if (w >= 0) g[w] = 1'b1;
        return g;
    endfunction

    function automatic logic [5:0] exp_credits();
        logic [5:0] c;
        c[2:0] = m_credit[0][2:0];
        c[5:3] = m_credit[1][2:0];
        return c;
    endfunction

    task automatic model_step();
        int w, wv, v;
        bit g, r;
        if (noc_rst) begin
            for (int j = 0; j < NUM_VC; j++) begin
                m_credit[j] = DEPTH;
                m_busy[j]   = 1'b0;
                m_owner[j]  = 0;
            end
            m_rr  = 0;
            m_err = 1'b0;
        end else begin
            w  = model_winner();
            wv = (w >= 0) ? int'(req_vc[w]) : -1;
            for (int i = 0; i < NUM_IN; i++) begin
                v = int'(req_vc[i]);
                if (req[i] && m_busy[v] && m_owner[v] == i && req_head[i]) m_err = 1'b1;
            end
            for (int j = 0; j < NUM_VC; j++) begin
                g = (wv == j);
                r = credit_return[j];
                if (g && !r) m_credit[j]--;
                else if (!g && r) begin
                    if (m_credit[j] == DEPTH) m_err = 1'b1;
                    else m_credit[j]++;
                end
            end
            if (w >= 0) begin
                if (!m_busy[wv]) begin
                    if (!req_tail[w]) begin
                        m_busy[wv]  = 1'b1;
                        m_owner[wv] = w;
                    end
                end else if (req_tail[w]) begin
                    m_busy[wv] = 1'b0;
                end
                m_rr = (w + 1) % NUM_IN;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge noc_clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] r, input logic [4:0] v, input logic [4:0] h,
                         input logic [4:0] t, input logic [1:0] cr);
        req = r; req_vc = v; req_head = h; req_tail = t; credit_return = cr;
        #2;
    endtask

    task automatic do_reset();
        noc_rst = 1'b1;
        drive(5'b0, 5'b0, 5'b0, 5'b0, 2'b0);
        tick();
        noc_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(5'b0, 5'b0, 5'b0, 5'b0, 2'b0);
        n_vec++;
        if (grant !== 5'b0 || out_valid !== 1'b0 || out_sel !== 3'd0 || out_vc !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle: got grant=%b valid=%b sel=%0d vc=%0d expected all zero", grant, out_valid, out_sel, out_vc);
        end
        n_vec++;
        if (credit_cnt !== 6'b100_100) begin
            n_bad++; $display("FAIL reset_credits: got %b expected %b", credit_cnt, 6'b100_100);
        end
        n_vec++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL reset_err: got %b expected 0", err);
        end
        tick();
    endtask

    task automatic test_single_flit();
        do_reset();
        drive(5'b00001, 5'b0, 5'b00001, 5'b00001, 2'b0);
        n_vec++;
        if (grant !== 5'b00001 || grant !== exp_grant() || out_vc !== 1'b0 || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL single_grant: got grant=%b vc=%0d valid=%b expected 00001/0/1", grant, out_vc, out_valid);
        end
        tick();
        drive(5'b00011, 5'b0, 5'b00011, 5'b00011, 2'b0);
        n_vec++;
        if (credit_cnt[2:0] !== 3'd3) begin
            n_bad++; $display("FAIL single_credit: got %0d expected 3", credit_cnt[2:0]);
        end
        n_vec++;
        if (grant !== 5'b00010 || out_sel !== 3'd1) begin
            n_bad++; $display("FAIL single_rr_next: got grant=%b sel=%0d expected 00010/1", grant, out_sel);
        end
        tick();
    endtask

    task automatic test_alternate();
        logic [4:0] want;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(5'b00101, 5'b0, 5'b00101, 5'b00101, 2'b01);
            want = (k % 2 == 0) ? 5'b00001 : 5'b00100;
            n_vec++;
            if (grant !== want || grant !== exp_grant()) begin
                n_bad++; $display("FAIL alternate_grant[%0d]: got %b expected %b", k, grant, want);
            end
            n_vec++;
            if (credit_cnt[2:0] !== 3'd4) begin
                n_bad++; $display("FAIL alternate_credit[%0d]: got %0d expected 4", k, credit_cnt[2:0]);
            end
            tick();
        end
    endtask

    task automatic test_wormhole_stall();
        logic [4:0] t_req  [5] = '{5'b00010, 5'b01010, 5'b01010, 5'b01010, 5'b01000};
        logic [4:0] t_head [5] = '{5'b00010, 5'b01000, 5'b01000, 5'b01000, 5'b01000};
        logic [4:0] t_tail [5] = '{5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b01000};
        logic [4:0] t_want [5] = '{5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b01000};
        do_reset();
        for (int s = 0; s < 5; s++) begin
            drive(t_req[s], 5'b11111, t_head[s], t_tail[s], 2'b10);
            n_vec++;
            if (grant !== t_want[s] || grant !== exp_grant() || out_vc !== 1'b1) begin
                n_bad++; $display("FAIL wormhole_grant[%0d]: got %b vc=%0d expected %b vc=1", s, grant, out_vc, t_want[s]);
            end
            tick();
        end
        drive(5'b0, 5'b0, 5'b0, 5'b0, 2'b0);
        n_vec++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL wormhole_err: got %b expected 0", err);
        end
        tick();
    endtask

    task automatic test_credit_exhaust();
        int f = 0;
        int ngr = 0;
        logic [4:0] want;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(5'b00001, 5'b0, {4'b0, f == 0}, {4'b0, f == 5}, 2'b00);
            want = (c < 4) ? 5'b00001 : 5'b00000;
            n_vec++;
            if (grant !== want || grant !== exp_grant()) begin
                n_bad++; $display("FAIL exhaust_grant[%0d]: got %b expected %b", c, grant, want);
            end
            if (model_winner() == 0) begin f++; ngr++; end
            tick();
        end
        for (int c = 0; c < 2; c++) begin
            drive(5'b0, 5'b0, 5'b0, 5'b0, 2'b01);
            tick();
        end
        drive(5'b0, 5'b0, 5'b0, 5'b0, 2'b00);
        n_vec++;
        if (credit_cnt[2:0] !== 3'd2 || ngr != 4) begin
            n_bad++; $display("FAIL exhaust_refill: got credit %0d expected 2 (bench grants %0d)", credit_cnt[2:0], ngr);
        end
        for (int c = 0; c < 3; c++) begin
            if (f < 6) drive(5'b00001, 5'b0, 5'b0, {4'b0, f == 5}, 2'b00);
            else       drive(5'b0, 5'b0, 5'b0, 5'b0, 2'b00);
            want = (c < 2) ? 5'b00001 : 5'b00000;
            n_vec++;
            if (grant !== want || grant !== exp_grant()) begin
                n_bad++; $display("FAIL exhaust_resume[%0d]: got %b expected %b", c, grant, want);
            end
            if (model_winner() == 0) f++;
            tick();
        end
        drive(5'b0, 5'b0, 5'b0, 5'b0, 2'b01);
        tick();
        drive(5'b00100, 5'b0, 5'b00100, 5'b00100, 2'b00);
        n_vec++;
        if (grant !== 5'b00100 || grant !== exp_grant()) begin
            n_bad++; $display("FAIL exhaust_released: got %b expected 00100", grant);
        end
        tick();
    endtask

    task automatic test_credit_overflow();
        do_reset();
        drive(5'b0, 5'b0, 5'b0, 5'b0, 2'b10);
        n_vec++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL overflow_pre_err: got %b expected 0", err);
        end
        tick();
        drive(5'b0, 5'b0, 5'b0, 5'b0, 2'b00);
        n_vec++;
        if (credit_cnt[5:3] !== 3'd4 || err !== 1'b1) begin
            n_bad++; $display("FAIL overflow_sat: got credit %0d err %b expected 4/1", credit_cnt[5:3], err);
        end
        for (int c = 0; c < 3; c++) tick();
        n_vec++;
        if (err !== 1'b1) begin
            n_bad++; $display("FAIL overflow_sticky: got %b expected 1", err);
        end
    endtask

    task automatic test_reset_mid_packet();
        drive(5'b00100, 5'b0, 5'b00100, 5'b0, 2'b0);
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(5'b00100, 5'b0, 5'b0, 5'b0, 2'b0);
            tick();
        end
        noc_rst = 1'b1;
        drive(5'b00100, 5'b0, 5'b0, 5'b0, 2'b0);
        n_vec++;
        if (credit_cnt[2:0] !== 3'd1 || grant !== 5'b00100 || grant !== exp_grant()) begin
            n_bad++; $display("FAIL midrst_pre: got credit %0d grant %b expected 1/00100", credit_cnt[2:0], grant);
        end
        tick();
        noc_rst = 1'b0;
        drive(5'b10010, 5'b00010, 5'b10010, 5'b10010, 2'b0);
        n_vec++;
        if (grant !== 5'b00010 || grant !== exp_grant()) begin
            n_bad++; $display("FAIL midrst_rr: got %b expected 00010", grant);
        end
        n_vec++;
        if (credit_cnt !== 6'b100_100 || err !== 1'b0) begin
            n_bad++; $display("FAIL midrst_state: got credits %b err %b expected 100100/0", credit_cnt, err);
        end
        tick();
        drive(5'b10000, 5'b0, 5'b10000, 5'b0, 2'b0);
        n_vec++;
        if (grant !== 5'b10000 || grant !== exp_grant()) begin
            n_bad++; $display("FAIL midrst_unlock: got %b expected 10000", grant);
        end
        tick();
    endtask

    task automatic test_random();
        logic [4:0] r, v, h, t, eg;
        logic [1:0] cr;
        int w;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            noc_rst = ($urandom_range(0, 59) == 0);
            r  = 5'($urandom);
            v  = 5'($urandom);
            for (int i = 0; i < NUM_IN; i++) begin
                h[i] = ($urandom_range(0, 2) == 0);
                t[i] = ($urandom_range(0, 2) == 0);
            end
            cr[0] = ($urandom_range(0, 3) == 0);
            cr[1] = ($urandom_range(0, 3) == 0);
            drive(r, v, h, t, cr);
            w  = model_winner();
            eg = exp_grant();
            n_vec++;
            if (grant !== eg || out_valid !== (w >= 0) || out_sel !== ((w >= 0) ? 3'(w) : 3'd0)
                || out_vc !== ((w >= 0) ? req_vc[w] : 1'b0)) begin
                n_bad++; $display("FAIL random_grant[%0d]: got grant=%b sel=%0d vc=%0d expected grant=%b", n, grant, out_sel, out_vc, eg);
            end
            n_vec++;
            if (credit_cnt !== exp_credits() || err !== m_err) begin
                n_bad++; $display("FAIL random_state[%0d]: got credits=%b err=%b expected %b/%b", n, credit_cnt, err, exp_credits(), m_err);
            end
            tick();
        end
        noc_rst = 1'b0;
    endtask

    initial begin
        noc_rst = 1'b1;
        req = 5'b0; req_vc = 5'b0; req_head = 5'b0; req_tail = 5'b0; credit_return = 2'b0;
        test_reset();
        test_single_flit();
        test_alternate();
        test_wormhole_stall();
        test_credit_exhaust();
        test_credit_overflow();
        test_reset_mid_packet();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
